// File: rtl/alu_pkg.sv
// Shared ALU opcodes, FSM state encoding and opcode helpers for the execution stage.
package alu_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_MUL = 4'b0100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // True for the opcodes that finish in a single cycle.
    function automatic logic is_single_cycle(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == ALU_AND) || (ctrl == ALU_OR) ||
               (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the multicycle controller and the ALU.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_pkg::*;

    logic                start;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    result;
    logic                zero;
    logic                busy;
    logic                done;
    logic                illegal;

    modport master (
        output start, alu_ctrl, a, b,
        input  result, zero, busy, done, illegal
    );

    modport slave (
        input  start, alu_ctrl, a, b,
        output result, zero, busy, done, illegal
    );

endinterface

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add multiplier datapath; one multiplier bit is consumed per step.
module mul_shift_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] acc_sum_c_o,
    output logic             last_c_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    // Accumulator value after the current step; also the final product on the last step.
    assign acc_sum_c_o = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_c_o    = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_sum_c_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle logic/arith ops plus an iterative WIDTH-cycle multiply.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_alu_if.slave   bus
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             illegal_q;

    logic [WIDTH-1:0] op_res_c;
    logic [WIDTH-1:0] acc_sum_c;
    logic             mul_load_c;
    logic             mul_step_c;
    logic             mul_last_c;

    // Single-cycle result; unsupported codes produce zero.
    always_comb begin
        op_res_c = '0;
        case (bus.alu_ctrl)
            ALU_AND: op_res_c = bus.a & bus.b;
            ALU_OR:  op_res_c = bus.a | bus.b;
            ALU_ADD: op_res_c = bus.a + bus.b;
            ALU_SUB: op_res_c = bus.a - bus.b;
            default: op_res_c = '0;
        endcase
    end

    assign mul_load_c = (state_q == ST_IDLE) && bus.start && (bus.alu_ctrl == ALU_MUL);
    assign mul_step_c = (state_q == ST_MUL);

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk         (clk),
        .rst         (reset),
        .load_i      (mul_load_c),
        .step_i      (mul_step_c),
        .mcand_i     (bus.a),
        .mplier_i    (bus.b),
        .acc_sum_c_o (acc_sum_c),
        .last_c_o    (mul_last_c)
    );

    // Control FSM and output registers; start is only honoured in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_ctrl == ALU_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            result_q  <= op_res_c;
                            illegal_q <= !is_single_cycle(bus.alu_ctrl);
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last_c) begin
                        result_q  <= acc_sum_c;
                        illegal_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.zero    = (result_q == '0);
    assign bus.busy    = (state_q == ST_MUL);
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expectations queued at issue, checked on every done pulse.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [3:0] ctrl, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic ill);
        ill = 1'b0;
        case (ctrl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0011: res = a - b;
            4'b0100: res = a * b;
            default: begin res = '0; ill = 1'b1; end
        endcase
    endfunction

    // Drive one request at the current negedge; start stays high until changed.
    task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit track);
        exp_t e;
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.a        = a;
        bus.b        = b;
        if (track) begin
            model(ctrl, a, b, e.res, e.ill);
            e.cyc = cyc + ((ctrl == ALU_MUL) ? 1 + int'(W) : 1);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.start = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: cycle %0d result %h, no request outstanding",
                             cyc, bus.result);
                end else begin
                    e = sb.pop_front();
                    if (bus.result !== e.res || bus.illegal !== e.ill ||
                        bus.zero !== (e.res == '0) || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL done_check: got res=%h ill=%b zero=%b cyc=%0d, expected res=%h ill=%b zero=%b cyc=%0d",
                                 bus.result, bus.illegal, bus.zero, cyc,
                                 e.res, e.ill, (e.res == '0), e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.result !== '0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s: got res=%h zero=%b busy=%b done=%b ill=%b, expected 0/1/0/0/0",
                     tag, bus.result, bus.zero, bus.busy, bus.done, bus.illegal);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.alu_ctrl = '0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset_values");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_sub();
        issue(ALU_SUB, 32'd5, 32'd5, 1'b1);
        issue(ALU_SUB, 32'd3, 32'd5, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        issue(ALU_MUL, a, b, 1'b1);
        idle();
        for (int i = 0; i < 100 && !bus.done; i++) begin
            if (bus.busy) n++;
            @(negedge clk);
        end
        checks++;
        if (n != int'(W)) begin
            errors++;
            $display("FAIL mul_busy_cycles: got %0d, expected %0d", n, W);
        end
        drain();
    endtask

    task automatic test_busy_ignore();
        issue(ALU_MUL, 32'd123, 32'd45, 1'b1);
        idle();
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = ALU_ADD; bus.a = 32'd1; bus.b = 32'd1;
        @(negedge clk);
        idle();
        for (int i = 0; i < 64 && !bus.done; i++) @(negedge clk);
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL mul_done_timeout: got done=%b, expected 1", bus.done);
        end
        issue(ALU_ADD, 32'd1, 32'd1, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_illegal();
        issue(4'b0111, 32'd9, 32'd9, 1'b1);
        for (int c = 5; c < 16; c++) issue(4'(c), $urandom, $urandom, 1'b1);
        issue(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++)
            issue(4'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
        idle();
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int dones = 0;
        issue(ALU_MUL, 32'd1000, 32'd1000, 1'b0);
        idle();
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("async_reset_mid_mul");
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL aborted_mul_done: got %0d done pulses, expected 0", dones);
        end
        issue(ALU_MUL, 32'd3, 32'd4, 1'b1);
        idle();
        drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_sub();
        test_mul(32'd7, 32'd6);
        test_mul(32'hFFFF_FFFF, 32'd2);
        test_mul(32'h1234_5678, 32'd0);
        test_mul(32'hDEAD_BEEF, 32'hCAFE_F00D);
        test_busy_ignore();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
